// File: rtl/ctech_lib_rr_arb.sv
// Round-robin arbiter granting one shared ctech resource to one of N requesters,
// with registered one-hot grant, release/request-drop exit and optional hold timeout.
module ctech_lib_rr_arb #(
  parameter int N        = 4,
  parameter int MAX_HOLD = 15,
  localparam int IDW     = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst_b,
  input  logic [N-1:0]   req,
  input  logic           rel,
  output logic [N-1:0]   gnt,
  output logic           gnt_vld,
  output logic [IDW-1:0] gnt_id,
  output logic           timeout
);

  // A zero MAX_HOLD still needs a legal counter width; the counter is then unused.
  localparam int HCW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;

  typedef enum logic {IDLE, GRANT} state_e;

  state_e         state_q, state_d;
  logic [N-1:0]   gnt_q, gnt_d;
  logic           vld_q, vld_d;
  logic [IDW-1:0] gnt_id_q, gnt_id_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [HCW-1:0] hold_q, hold_d;
  logic           tmo_q, tmo_d;

  logic           found;
  logic [IDW-1:0] win;
  logic [IDW:0]   srch_idx;
  logic           rel_exit;
  logic           tmo_exit;

  // Search order ptr, ptr+1, ..., wrapping modulo N; first set request wins.
  always_comb begin
    found    = 1'b0;
    win      = '0;
    srch_idx = '0;
    for (int k = 0; k < N; k++) begin
      srch_idx = {1'b0, ptr_q} + (IDW+1)'(k);
      if (srch_idx >= (IDW+1)'(N)) srch_idx = srch_idx - (IDW+1)'(N);
      if (!found && req[srch_idx[IDW-1:0]]) begin
        found = 1'b1;
        win   = srch_idx[IDW-1:0];
      end
    end
  end

  assign rel_exit = rel || !req[gnt_id_q];
  assign tmo_exit = (MAX_HOLD != 0) && (hold_q == HCW'(MAX_HOLD));

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    vld_d    = vld_q;
    gnt_id_d = gnt_id_q;
    ptr_d    = ptr_q;
    hold_d   = hold_q;
    tmo_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          gnt_d      = '0;
          gnt_d[win] = 1'b1;
          vld_d      = 1'b1;
          gnt_id_d   = win;
          hold_d     = HCW'(1);
          state_d    = GRANT;
        end
      end
      GRANT: begin
        if (rel_exit || tmo_exit) begin
          gnt_d   = '0;
          vld_d   = 1'b0;
          ptr_d   = (gnt_id_q == IDW'(N - 1)) ? '0 : gnt_id_q + IDW'(1);
          // An owner-initiated exit in the same cycle is not a forced revoke.
          tmo_d   = tmo_exit && !rel_exit;
          state_d = IDLE;
        end else begin
          hold_d = hold_q + HCW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q  <= IDLE;
      gnt_q    <= '0;
      vld_q    <= 1'b0;
      gnt_id_q <= '0;
      ptr_q    <= '0;
      hold_q   <= '0;
      tmo_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      vld_q    <= vld_d;
      gnt_id_q <= gnt_id_d;
      ptr_q    <= ptr_d;
      hold_q   <= hold_d;
      tmo_q    <= tmo_d;
    end
  end

  assign gnt     = gnt_q;
  assign gnt_vld = vld_q;
  assign gnt_id  = gnt_id_q;
  assign timeout = tmo_q;

endmodule
